puf_test_ctrl: RTL and testbench

Parametrised successor of the PUF self-test FSM. It issues PUF triggers and challenges, and picks one response bit per evaluation (any raw bit or the XOR bit). It streams those bits to an external randomness-test block and accumulates per-test pass counts over a configurable number of rounds. At the end it writes the counts to result memory. It sits between the challenge generator, the mapping PUF core, the NIST tester and the result BRAM, and reports completion to the host-side FSM.

---
 rtl/puf_test_pkg.sv | 30 +++
 rtl/puf_pass_accum.sv | 41 ++++
 rtl/puf_test_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_puf_test_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_test_pkg.sv
// Shared types and helpers for the PUF self-test controller.
// Holds the FSM state encoding, the counter-width helper and saturating addition.
package puf_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ISSUE,
        WAIT_PUF,
        WAIT_RES,
        STORE,
        DONE
    } state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cw(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] v,
                                            input logic [31:0] inc,
                                            input logic [31:0] maxv);
        logic [32:0] s;
        s = {1'b0, v} + {1'b0, inc};
        return (s > {1'b0, maxv}) ? maxv : s[31:0];
    endfunction

endpackage

// File: rtl/puf_pass_accum.sv
// Bank of NUM_TESTS saturating pass counters with synchronous clear, a shared
// increment enable and an indexed read port used while results are stored.
module puf_pass_accum
    import puf_test_pkg::*;
#(
    parameter int NUM_TESTS = 8,
    parameter int CNT_W     = 8,
    parameter int IDX_W     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_en,
    input  logic [NUM_TESTS-1:0] i_result,
    input  logic [IDX_W-1:0]     i_idx,
    output logic [CNT_W-1:0]     o_rdata
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] r_cnt [NUM_TESTS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_TESTS; i++) r_cnt[i] <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < NUM_TESTS; i++) r_cnt[i] <= '0;
        end else if (i_en) begin
            for (int i = 0; i < NUM_TESTS; i++)
                r_cnt[i] <= CNT_W'(sat_add(32'(r_cnt[i]), 32'(i_result[i]), CNT_MAX));
        end
    end

    // Indices beyond the bank (e.g. the bias slot) read back as zero.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < NUM_TESTS; i++)
            if (i_idx == IDX_W'(i)) o_rdata = r_cnt[i];
    end

endmodule

// File: rtl/puf_test_ctrl.sv
// PUF self-test controller: triggers evaluations, streams one selected response
// bit per evaluation to the tester, accumulates pass counts and stores them.
// Optional macro PUF_TEST_BIAS_EN adds a ones counter written after the pass counts.
module puf_test_ctrl
    import puf_test_pkg::*;
#(
    parameter int CHALLENGE_WIDTH = 32,
    parameter int RESP_W          = 6,
    parameter int NUM_TESTS       = 8,
    parameter int BITS_PER_ROUND  = 20000,
    parameter int NUM_ROUNDS      = 255,
    parameter int CNT_W           = 8,
    parameter int ADDR_W          = 13,
    parameter int DATA_W          = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [cw(RESP_W)-1:0]      i_resp_sel,
    input  logic                       i_use_xor,
    input  logic [CHALLENGE_WIDTH-1:0] i_rng_c,
    output logic [CHALLENGE_WIDTH-1:0] o_challenge,
    output logic                       o_puf_trigger,
    input  logic                       i_puf_done,
    input  logic [RESP_W-1:0]          i_raw_response,
    input  logic                       i_xor_response,
    output logic                       o_test_bit,
    output logic                       o_test_bit_valid,
    output logic                       o_round_end,
    input  logic                       i_result_valid,
    input  logic [NUM_TESTS-1:0]       i_test_result,
    output logic                       o_mem_we,
    output logic [ADDR_W-1:0]          o_mem_waddr,
    output logic [DATA_W-1:0]          o_mem_din,
    output logic                       o_busy,
    output logic                       o_test_done
);

    localparam int RSEL_W = cw(RESP_W);
    localparam int BIT_W  = cw(BITS_PER_ROUND);
    localparam int RND_W  = cw(NUM_ROUNDS);
`ifdef PUF_TEST_BIAS_EN
    localparam int STORE_LEN = NUM_TESTS + 1;
`else
    localparam int STORE_LEN = NUM_TESTS;
`endif
    localparam int IDX_W  = cw(STORE_LEN);

    state_t                     r_state;
    state_t                     w_next;
    logic [BIT_W-1:0]           r_bit_cnt;
    logic [RND_W-1:0]           r_round_cnt;
    logic [IDX_W-1:0]           r_idx;
    logic [RSEL_W-1:0]          r_resp_sel;
    logic                       r_use_xor;
    logic [CHALLENGE_WIDTH-1:0] r_challenge;
    logic                       r_puf_trigger;
    logic                       r_test_bit;
    logic                       r_test_bit_valid;
    logic                       r_round_end;

    logic                       w_abort;
    logic                       w_launch;
    logic                       w_take_bit;
    logic                       w_take_res;
    logic                       w_last_bit;
    logic                       w_last_round;
    logic                       w_last_store;
    logic                       w_raw_bit;
    logic                       w_sel_bit;
    logic                       w_clear;
    logic [CNT_W-1:0]           w_pass_rdata;
    logic [DATA_W-1:0]          w_store_data;

    // Abort outranks every other event; it has no meaning while already idle.
    assign w_abort      = i_abort && (r_state != IDLE);
    assign w_launch     = i_start && ((r_state == IDLE) || (r_state == DONE)) && !w_abort;
    assign w_take_bit   = (r_state == WAIT_PUF) && i_puf_done && !w_abort;
    assign w_take_res   = (r_state == WAIT_RES) && i_result_valid && !w_abort;
    assign w_last_bit   = (r_bit_cnt == BIT_W'(BITS_PER_ROUND - 1));
    assign w_last_round = (r_round_cnt == RND_W'(NUM_ROUNDS - 1));
    assign w_last_store = (r_idx == IDX_W'(STORE_LEN - 1));
    assign w_clear      = (r_state == INIT);

    always_comb begin
        w_raw_bit = 1'b0;
        for (int i = 0; i < RESP_W; i++)
            if (r_resp_sel == RSEL_W'(i)) w_raw_bit = i_raw_response[i];
    end

    assign w_sel_bit = r_use_xor ? i_xor_response : w_raw_bit;

    puf_pass_accum #(
        .NUM_TESTS (NUM_TESTS),
        .CNT_W     (CNT_W),
        .IDX_W     (IDX_W)
    ) u_accum (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_clear),
        .i_en     (w_take_res),
        .i_result (i_test_result),
        .i_idx    (r_idx),
        .o_rdata  (w_pass_rdata)
    );

`ifdef PUF_TEST_BIAS_EN
    localparam int          TOTAL_W  = $clog2(BITS_PER_ROUND * NUM_ROUNDS);
    localparam int          BIAS_SH  = (TOTAL_W > DATA_W) ? (TOTAL_W - DATA_W) : 0;
    localparam logic [31:0] ONES_MAX = 32'((64'd1 << DATA_W) - 64'd1);

    logic [DATA_W-1:0] r_ones_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_ones_cnt <= '0;
        else if (w_clear)
            r_ones_cnt <= '0;
        else if (w_take_bit && w_sel_bit)
            r_ones_cnt <= DATA_W'(sat_add(32'(r_ones_cnt), 32'd1, ONES_MAX));
    end

    assign w_store_data = (r_idx == IDX_W'(NUM_TESTS)) ? DATA_W'(r_ones_cnt >> BIAS_SH)
                                                       : DATA_W'(w_pass_rdata);
`else
    assign w_store_data = DATA_W'(w_pass_rdata);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_launch) w_next = INIT;
            INIT:     w_next = ISSUE;
            ISSUE:    w_next = WAIT_PUF;
            WAIT_PUF: if (w_take_bit) w_next = w_last_bit ? WAIT_RES : ISSUE;
            WAIT_RES: if (w_take_res) w_next = w_last_round ? STORE : ISSUE;
            STORE:    if (w_last_store) w_next = DONE;
            DONE:     if (w_launch) w_next = INIT;
            default:  w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    always_comb begin
        o_busy      = (r_state != IDLE) && (r_state != DONE);
        o_test_done = (r_state == DONE);
        o_mem_we    = (r_state == STORE);
        o_mem_waddr = '0;
        o_mem_din   = '0;
        if (r_state == STORE) begin
            o_mem_waddr = ADDR_W'(r_idx);
            o_mem_din   = w_store_data;
        end
    end

    // Trigger is registered with the challenge so the PUF sees both together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt        <= '0;
            r_round_cnt      <= '0;
            r_idx            <= '0;
            r_resp_sel       <= '0;
            r_use_xor        <= 1'b0;
            r_challenge      <= '0;
            r_puf_trigger    <= 1'b0;
            r_test_bit       <= 1'b0;
            r_test_bit_valid <= 1'b0;
            r_round_end      <= 1'b0;
        end else begin
            r_puf_trigger    <= (r_state == ISSUE) && !w_abort;
            r_test_bit_valid <= w_take_bit;
            r_round_end      <= w_take_bit && w_last_bit;
            if (w_launch) begin
                r_resp_sel <= i_resp_sel;
                r_use_xor  <= i_use_xor;
            end
            if (w_clear) begin
                r_bit_cnt   <= '0;
                r_round_cnt <= '0;
                r_idx       <= '0;
            end
            if ((r_state == ISSUE) && !w_abort) r_challenge <= i_rng_c;
            if (w_take_bit) begin
                r_test_bit <= w_sel_bit;
                r_bit_cnt  <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
            end
            if (w_take_res)
                r_round_cnt <= w_last_round ? '0 : r_round_cnt + 1'b1;
            if ((r_state == STORE) && !w_abort)
                r_idx <= w_last_store ? '0 : r_idx + 1'b1;
        end
    end

    assign o_challenge      = r_challenge;
    assign o_puf_trigger    = r_puf_trigger;
    assign o_test_bit       = r_test_bit;
    assign o_test_bit_valid = r_test_bit_valid;
    assign o_round_end      = r_round_end;

endmodule

// File: tb/tb_puf_test_ctrl.sv
// Scoreboard bench for puf_test_ctrl with a small PUF model and tester model;
// expectations are queued at stimulus time and popped by a separate monitor.
module tb_puf_test_ctrl;

    localparam int CHW = 32;
    localparam int RW  = 6;
    localparam int NT  = 8;
    localparam int BPR = 4;
    localparam int NR  = 5;
    localparam int CW  = 2;
    localparam int AW  = 13;
    localparam int DW  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_start, i_abort, i_use_xor, i_puf_done, i_xor_response, i_result_valid;
    logic [2:0]      i_resp_sel;
    logic [CHW-1:0]  i_rng_c;
    logic [RW-1:0]   i_raw_response;
    logic [NT-1:0]   i_test_result;
    logic [CHW-1:0]  o_challenge;
    logic            o_puf_trigger, o_test_bit, o_test_bit_valid, o_round_end;
    logic            o_mem_we, o_busy, o_test_done;
    logic [AW-1:0]   o_mem_waddr;
    logic [DW-1:0]   o_mem_din;

    int              checks = 0;
    int              errors = 0;
    logic [1:0]      bitQ [$];
    logic [20:0]     wrQ [$];
    int              roundEndSeen = 0;
    logic [7:0]      resTable [NR];
    logic [31:0]     rngC = 32'h1234_5678;
    int              pufCnt = 0;
    int              resCnt = 0;
    int              roundIdx = 0;

    always #5 clk = ~clk;

    puf_test_ctrl #(
        .CHALLENGE_WIDTH (CHW), .RESP_W (RW), .NUM_TESTS (NT), .BITS_PER_ROUND (BPR),
        .NUM_ROUNDS (NR), .CNT_W (CW), .ADDR_W (AW), .DATA_W (DW)
    ) dut (
        .i_clk (clk), .i_rst_n (rst_n), .i_start (i_start), .i_abort (i_abort),
        .i_resp_sel (i_resp_sel), .i_use_xor (i_use_xor), .i_rng_c (i_rng_c),
        .o_challenge (o_challenge), .o_puf_trigger (o_puf_trigger), .i_puf_done (i_puf_done),
        .i_raw_response (i_raw_response), .i_xor_response (i_xor_response),
        .o_test_bit (o_test_bit), .o_test_bit_valid (o_test_bit_valid), .o_round_end (o_round_end),
        .i_result_valid (i_result_valid), .i_test_result (i_test_result),
        .o_mem_we (o_mem_we), .o_mem_waddr (o_mem_waddr), .o_mem_din (o_mem_din),
        .o_busy (o_busy), .o_test_done (o_test_done)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // PUF model: done two cycles after each trigger; also drives the free-running RNG.
    always @(negedge clk) begin
        if (!rst_n) begin
            pufCnt     = 0;
            i_puf_done = 1'b0;
        end else begin
            i_puf_done = 1'b0;
            if (pufCnt > 0) begin
                pufCnt--;
                if (pufCnt == 0) i_puf_done = 1'b1;
            end
            if (o_puf_trigger) begin
                checkOutput("challenge", 64'(o_challenge), 64'(rngC));
                pufCnt = 2;
            end
        end
        rngC    = rngC * 32'd1103515245 + 32'd12345;
        i_rng_c = rngC;
    end

    // Tester model: results three cycles after each round_end, from resTable in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            resCnt         = 0;
            roundIdx       = 0;
            i_result_valid = 1'b0;
            i_test_result  = '0;
        end else begin
            i_result_valid = 1'b0;
            if (resCnt > 0) begin
                resCnt--;
                if (resCnt == 0) begin
                    i_result_valid = 1'b1;
                    i_test_result  = resTable[roundIdx];
                    roundIdx       = (roundIdx + 1) % NR;
                end
            end
            if (o_round_end) resCnt = 3;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a strobe or a write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_test_bit_valid) begin
                if (bitQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected strobe: bit %0b, none expected", o_test_bit);
                end else
                    checkOutput("strobe {round_end,bit}", 64'({o_round_end, o_test_bit}), 64'(bitQ.pop_front()));
            end
            if (o_round_end) begin
                roundEndSeen++;
                if (!o_test_bit_valid) begin
                    checks++; errors++;
                    $display("[TB] FAIL round_end without strobe: valid %0b, required 1", o_test_bit_valid);
                end
            end
            if (o_mem_we) begin
                if (wrQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected write: addr %0d data %0d, none expected", o_mem_waddr, o_mem_din);
                end else
                    checkOutput("mem {addr,data}", 64'({o_mem_waddr, o_mem_din}), 64'(wrQ.pop_front()));
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] sel, input logic useXor, input logic [RW-1:0] raw,
                                 input logic xr, input int nBits, input logic expBit);
        @(negedge clk);
        i_resp_sel     = sel;
        i_use_xor      = useXor;
        i_raw_response = raw;
        i_xor_response = xr;
        for (int i = 0; i < nBits; i++)
            bitQ.push_back({((i % BPR) == BPR - 1) ? 1'b1 : 1'b0, expBit});
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic pushWrites(input logic [63:0] counts, input int n, input logic [7:0] bias);
        for (int i = 0; i < n; i++)
            wrQ.push_back({AW'(i), counts[i*8 +: 8]});
`ifdef PUF_TEST_BIAS_EN
        if (n == NT) wrQ.push_back({AW'(NT), bias});
`endif
    endtask

    task automatic waitDone(input int bound);
        int n = 0;
        while (!o_test_done && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("run reaches DONE", 64'(o_test_done), 64'd1);
    endtask

    initial begin
        int reBase;
        int n;
        rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_resp_sel = '0; i_use_xor = 1'b0;
        i_raw_response = '0; i_xor_response = 1'b0;
        for (int i = 0; i < NR; i++) resTable[i] = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset busy", 64'(o_busy), 64'd0);
        checkOutput("reset test_done", 64'(o_test_done), 64'd0);
        checkOutput("reset mem_we", 64'(o_mem_we), 64'd0);
        checkOutput("reset puf_trigger", 64'(o_puf_trigger), 64'd0);
        checkOutput("reset test_bit_valid", 64'(o_test_bit_valid), 64'd0);
        checkOutput("reset round_end", 64'(o_round_end), 64'd0);
        checkOutput("reset challenge", 64'(o_challenge), 64'd0);
        checkOutput("reset mem_waddr", 64'(o_mem_waddr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] run 1: raw bit 3, rounds A5,A5,00,00,00");
        resTable = '{8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00};
        reBase = roundEndSeen;
        pushWrites(64'h02_00_02_00_00_02_00_02, NT, 8'd20);
        applyStimulus(3'd3, 1'b0, 6'b001000, 1'b0, NR * BPR, 1'b1);
        checkOutput("busy after start", 64'(o_busy), 64'd1);
        i_resp_sel = 3'd0;
        i_use_xor  = 1'b1;
        repeat (30) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        waitDone(2000);
        checkOutput("run1 busy in DONE", 64'(o_busy), 64'd0);
        checkOutput("run1 round_end count", 64'(roundEndSeen - reBase), 64'(NR));
        checkOutput("run1 strobes consumed", 64'(bitQ.size()), 64'd0);
        checkOutput("run1 writes consumed", 64'(wrQ.size()), 64'd0);
        repeat (5) @(negedge clk);
        checkOutput("test_done held", 64'(o_test_done), 64'd1);

        $display("[TB] run 2: xor bit 0, rounds FF saturate");
        resTable = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        pushWrites(64'h03_03_03_03_03_03_03_03, NT, 8'd0);
        applyStimulus(3'd0, 1'b1, 6'b111111, 1'b0, NR * BPR, 1'b0);
        checkOutput("test_done cleared on restart", 64'(o_test_done), 64'd0);
        waitDone(2000);
        checkOutput("run2 writes consumed", 64'(wrQ.size()), 64'd0);

        $display("[TB] run 3: abort with third puf_done");
        applyStimulus(3'd3, 1'b0, 6'b110111, 1'b1, 2, 1'b0);
        n = 0;
        for (int k = 0; k < 500 && n < 3; k++) begin
            @(negedge clk);
            #1;
            if (i_puf_done) n++;
        end
        checkOutput("abort point reached", 64'(n), 64'd3);
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort busy", 64'(o_busy), 64'd0);
        checkOutput("abort no strobe", 64'(o_test_bit_valid), 64'd0);
        @(negedge clk);
        i_abort = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("abort test_done", 64'(o_test_done), 64'd0);
        checkOutput("abort strobes consumed", 64'(bitQ.size()), 64'd0);

        $display("[TB] run 4: fresh run after abort");
        resTable = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        reBase = roundEndSeen;
        pushWrites(64'h00_00_00_01_01_01_01_01, NT, 8'd20);
        applyStimulus(3'd5, 1'b0, 6'b100000, 1'b0, NR * BPR, 1'b1);
        waitDone(2000);
        checkOutput("run4 round_end count", 64'(roundEndSeen - reBase), 64'(NR));
        checkOutput("run4 writes consumed", 64'(wrQ.size()), 64'd0);

        $display("[TB] run 5: abort on third STORE cycle");
        resTable = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        pushWrites(64'h0, 3, 8'd0);
        applyStimulus(3'd3, 1'b1, 6'b000000, 1'b1, NR * BPR, 1'b1);
        n = 0;
        while (!(o_mem_we && o_mem_waddr == AW'(2)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("third store cycle reached", 64'(o_mem_waddr), 64'd2);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        checkOutput("store abort mem_we", 64'(o_mem_we), 64'd0);
        checkOutput("store abort test_done", 64'(o_test_done), 64'd0);
        checkOutput("store abort busy", 64'(o_busy), 64'd0);
        repeat (10) @(negedge clk);
        checkOutput("run5 writes consumed", 64'(wrQ.size()), 64'd0);
        checkOutput("run5 strobes consumed", 64'(bitQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
